// File: rtl/uart_rx_param_if.sv
// Parallel-side bundle of uart_rx_param: held word with valid/ready handshake plus per-frame error pulses.
interface uart_rx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  par_err;
    logic                  stp_err;
    logic                  overrun;

    modport master (output p_data, output out_valid, output par_err, output stp_err, output overrun,
                    input  out_ready);
    modport slave  (input  p_data, input  out_valid, input  par_err, input  stp_err, input  overrun,
                    output out_ready);
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with majority vote, glitch reject and a one-deep output holding stage.
// Outputs register one cycle after the last stop bit's centre sample; a full, stalled stage drops new words as OVERRUN.
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_in,
    input  logic               i_par_en,
    input  logic               i_par_typ,
    input  logic               i_stop2,
    input  logic [PRESC_W-1:0] i_prescale,
    uart_rx_param_if.master    o_rx
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state, w_next;
    logic                  r_rx_meta, r_rx_s;
    logic                  r_par_en, r_par_typ, r_stop2;
    logic [PRESC_W-1:0]    r_presc, r_edge_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_s0, r_s1, r_par_bad, r_stp_bad, r_wait_hi;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_out_valid, r_par_err, r_stp_err, r_overrun;

    logic [PRESC_W-1:0]    w_half, w_pre_pt, w_mid_pt, w_end_pt;
    logic                  w_mid, w_end, w_maj, w_last_data, w_last_stop;
    logic                  w_start_go, w_shift_en, w_par_chk, w_stop_smp, w_decide;
    logic                  w_stp_fail, w_good;

    assign w_half      = r_presc >> 1;
    assign w_pre_pt    = w_half - PRESC_W'(1);
    assign w_mid_pt    = w_half + PRESC_W'(1);
    assign w_end_pt    = r_presc - PRESC_W'(1);
    assign w_mid       = (r_edge_cnt == w_mid_pt);
    assign w_end       = (r_edge_cnt == w_end_pt);
    assign w_maj       = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_last_data = (r_bit_cnt == 4'(DATA_WIDTH - 1));
    assign w_last_stop = !r_stop2 || (r_bit_cnt == 4'd1);
    assign w_stp_fail  = r_stp_bad | ~w_maj;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s && !r_wait_hi) w_next = S_START;
            S_START:  if (w_mid && w_maj) w_next = S_IDLE;
                      else if (w_end)     w_next = S_DATA;
            S_DATA:   if (w_end && w_last_data) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_end) w_next = S_STOP;
            // Leave at the last stop's centre so the next start edge is not missed.
            S_STOP:   if (w_mid && w_last_stop) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start_go = (r_state == S_IDLE) && (w_next == S_START);
        w_shift_en = (r_state == S_DATA) && w_mid;
        w_par_chk  = (r_state == S_PARITY) && w_mid;
        w_stop_smp = (r_state == S_STOP) && w_mid;
        w_decide   = w_stop_smp && w_last_stop;
        w_good     = w_decide && !w_stp_fail && !r_par_bad;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_presc    <= '0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            r_wait_hi  <= 1'b0;
        end else begin
            r_rx_meta <= i_rx_in;
            r_rx_s    <= r_rx_meta;
            if (r_rx_s) r_wait_hi <= 1'b0;
            // The detection cycle in IDLE is edge 0 of the start bit, so counting resumes at 1.
            if (w_start_go) begin
                r_par_en   <= i_par_en;
                r_par_typ  <= i_par_typ;
                r_stop2    <= i_stop2;
                r_presc    <= i_prescale;
                r_edge_cnt <= PRESC_W'(1);
                r_bit_cnt  <= '0;
                r_par_bad  <= 1'b0;
                r_stp_bad  <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_edge_cnt <= w_end ? '0 : r_edge_cnt + PRESC_W'(1);
                if (w_end)
                    r_bit_cnt <= (((r_state == S_DATA) && !w_last_data) || (r_state == S_STOP))
                                 ? r_bit_cnt + 4'd1 : 4'd0;
            end
            if (r_edge_cnt == w_pre_pt) r_s0 <= r_rx_s;
            if (r_edge_cnt == w_half)   r_s1 <= r_rx_s;
            if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
            if (w_par_chk)  r_par_bad <= (w_maj != (^r_shift ^ r_par_typ));
            if (w_stop_smp && !w_maj) r_stp_bad <= 1'b1;
            // A failed stop usually means a held-low line; re-arm only after it returns high.
            if (w_decide && w_stp_fail) r_wait_hi <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p_data    <= '0;
            r_out_valid <= 1'b0;
            r_par_err   <= 1'b0;
            r_stp_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_par_err <= w_decide && r_par_bad;
            r_stp_err <= w_decide && w_stp_fail;
            r_overrun <= w_good && r_out_valid && !o_rx.out_ready;
            if (w_good && (!r_out_valid || o_rx.out_ready)) begin
                r_p_data    <= r_shift;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && o_rx.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_rx.p_data    = r_p_data;
    assign o_rx.out_valid = r_out_valid;
    assign o_rx.par_err   = r_par_err;
    assign o_rx.stp_err   = r_stp_err;
    assign o_rx.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8-bit and 5-bit words), frame-level reference model and event scoreboard.
module tb_uart_rx_param;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_a, rx_b, par_en, par_typ, stop2, ready;
    logic [PW-1:0] presc;
    longint        cyc = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_WIDTH(8)) a_if ();
    uart_rx_param_if #(.DATA_WIDTH(5)) b_if ();
    assign a_if.out_ready = ready;
    assign b_if.out_ready = ready;

    uart_rx_param #(.DATA_WIDTH(8), .PRESC_W(PW)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx_a), .i_par_en(par_en), .i_par_typ(par_typ),
        .i_stop2(stop2), .i_prescale(presc), .o_rx(a_if.master));
    uart_rx_param #(.DATA_WIDTH(5), .PRESC_W(PW)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx_b), .i_par_en(par_en), .i_par_typ(par_typ),
        .i_stop2(stop2), .i_prescale(presc), .o_rx(b_if.master));

    typedef struct {
        int         id;
        bit         stp, par, ovr, load;
        logic [8:0] pd;
        longint     cyc;
    } exp_t;

    exp_t       q[$];
    bit         hv[2];
    logic [8:0] pd[2];
    logic       pv[2];
    logic       pr[2];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int id, input logic [8:0] p, input logic v, input logic pe,
                       input logic se, input logic ov);
        logic ld;
        exp_t e;
        ld = v && (!pv[id] || pr[id]);
        if (pe || se || ov || ld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: dut %0d flags %b at cycle %0d", id, {se, pe, ov, ld}, cyc);
            end else begin
                e = q.pop_front();
                check("evt_dut", longint'(id), longint'(e.id));
                check("evt_flags_stp_par_ovr_load", longint'({se, pe, ov, ld}),
                      longint'({e.stp, e.par, e.ovr, e.load}));
                check("p_data", longint'(p), longint'(e.pd));
                check("evt_cycle", cyc, e.cyc);
            end
        end
        pv[id] = v;
        pr[id] = ready;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv[0] = 1'b0; pv[1] = 1'b0;
        end else begin
            mon(0, {1'b0, a_if.p_data}, a_if.out_valid, a_if.par_err, a_if.stp_err, a_if.overrun);
            mon(1, {4'b0, b_if.p_data}, b_if.out_valid, b_if.par_err, b_if.stp_err, b_if.overrun);
        end
    end

    task automatic drive(input int id, input logic v);
        if (id == 0) rx_a = v;
        else         rx_b = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ready(input logic r);
        ready = r;
        if (r) begin hv[0] = 1'b0; hv[1] = 1'b0; end
    endtask

    // Model: one frame -> at most one decision event, timed from the RX_IN start edge.
    task automatic send_frame(input int id, input logic [8:0] data, input bit pe, input bit pt,
                              input bit s2, input int p, input bit bad_par, input bit bad_s1,
                              input bit bad_s2, input int glitch_bit, input int tail_low,
                              input bit scramble);
        int     dw, nb;
        logic   bits[$];
        logic   par, v;
        bit     stp, pbad;
        exp_t   e;
        longint c0;
        dw = (id == 0) ? 8 : 5;
        par_en = pe; par_typ = pt; stop2 = s2; presc = PW'(p);
        bits.push_back(1'b0);
        par = pt;
        for (int i = 0; i < dw; i++) begin
            bits.push_back(data[i]);
            par ^= data[i];
        end
        if (pe) bits.push_back(par ^ bad_par);
        bits.push_back(~bad_s1);
        if (s2) bits.push_back(~bad_s2);
        stp  = bad_s1 || (s2 && bad_s2);
        pbad = pe && bad_par;
        nb   = 1 + dw + int'(pe) + int'(s2);
        c0   = cyc;
        e.id = id; e.stp = stp; e.par = pbad; e.ovr = 1'b0; e.load = 1'b0;
        if (!stp && !pbad) begin
            if (hv[id] && !ready) e.ovr = 1'b1;
            else begin
                e.load = 1'b1;
                pd[id] = data;
                hv[id] = 1'b1;
            end
        end
        e.pd  = pd[id];
        e.cyc = c0 + longint'(nb * p + p / 2 + 4);
        if (ready) hv[id] = 1'b0;
        q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            for (int i = 0; i < p; i++) begin
                v = bits[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && i == p / 2) v = ~v;
                drive(id, v);
                @(posedge clk); #1;
                if (scramble && b == 1 && i == 0) begin
                    presc = PW'(8 + 2 * $urandom_range(0, 12));
                    par_en = ~pe; par_typ = ~pt; stop2 = ~s2;
                end
            end
        end
        if (tail_low > 0) begin
            drive(id, 1'b0);
            idle(tail_low);
        end
        drive(id, 1'b1);
        if (stp) idle(p);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_a"}, longint'(a_if.out_valid), 0);
        check({tag, "_pdata_a"}, longint'(a_if.p_data), 0);
        check({tag, "_pulses_a"}, longint'({a_if.par_err, a_if.stp_err, a_if.overrun}), 0);
        check({tag, "_valid_b"}, longint'(b_if.out_valid), 0);
        check({tag, "_pdata_b"}, longint'(b_if.p_data), 0);
        check({tag, "_pulses_b"}, longint'({b_if.par_err, b_if.stp_err, b_if.overrun}), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int      p, gap;
        bit      pe, pt, s2, bp, b1, b2;
        int      wait_cnt;
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; presc = PW'(16);
        hv[0] = 1'b0; hv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        pv[0] = 1'b0; pv[1] = 1'b0; pr[0] = 1'b0; pr[1] = 1'b0;
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(4);

        // Parity/stop handling at P=16, odd parity.
        send_frame(0, 9'h07F, 1, 1, 0, 16, 0, 0, 0, -1, 0, 0);  idle(10);
        send_frame(0, 9'h07F, 1, 1, 0, 16, 1, 0, 0, -1, 0, 0);  idle(10);
        send_frame(0, 9'h07F, 1, 1, 0, 16, 0, 1, 0, -1, 0, 0);  idle(10);
        send_frame(0, 9'h07F, 1, 1, 0, 16, 1, 1, 0, -1, 0, 0);  idle(10);
        // Two stop bits.
        send_frame(0, 9'h0A5, 0, 0, 1, 16, 0, 0, 1, -1, 0, 0);  idle(10);
        send_frame(0, 9'h0A5, 0, 0, 1, 16, 0, 0, 0, -1, 0, 0);  idle(10);
        // Short start glitch, then a single-cycle glitch on a data bit centre.
        drive(0, 1'b0); idle(5); drive(0, 1'b1); idle(40);
        send_frame(0, 9'h03C, 0, 0, 0, 16, 0, 0, 0, 2, 0, 0);   idle(10);
        // Break: line held low well past the frame.
        send_frame(0, 9'h000, 0, 0, 0, 16, 0, 1, 0, -1, 60, 0); idle(10);
        // Stalled consumer: second word is an overrun.
        set_ready(1'b0);
        send_frame(0, 9'h011, 0, 0, 0, 16, 0, 0, 0, -1, 0, 0);
        send_frame(0, 9'h022, 0, 0, 0, 16, 0, 0, 0, -1, 0, 0);  idle(10);
        set_ready(1'b1); idle(5);
        // Smallest and largest prescale.
        send_frame(0, 9'h0C3, 1, 0, 1, 8, 0, 0, 0, -1, 0, 0);
        send_frame(0, 9'h05A, 1, 0, 1, 32, 0, 0, 0, -1, 0, 0); idle(10);

        for (int n = 0; n < 24; n++) begin
            p  = 2 * int'($urandom_range(4, 16));
            pe = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
            bp = ($urandom_range(0, 5) == 0); b1 = ($urandom_range(0, 6) == 0); b2 = ($urandom_range(0, 6) == 0);
            set_ready($urandom_range(0, 3) != 0);
            send_frame(0, 9'($urandom_range(0, 255)), pe, pt, s2, p, bp, b1, b2, -1, 0,
                       $urandom_range(0, 1) == 1);
            gap = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 30));
            idle(gap);
        end
        set_ready(1'b1); idle(20);

        // 5-bit instance, P=8, back-to-back frames.
        send_frame(1, 9'h015, 0, 0, 0, 8, 0, 0, 0, -1, 0, 0);
        send_frame(1, 9'h00A, 0, 0, 0, 8, 0, 0, 0, -1, 0, 0);
        send_frame(1, 9'h01F, 0, 0, 0, 8, 0, 0, 0, -1, 0, 0);   idle(10);
        // Reset in the middle of a frame while a word is held.
        set_ready(1'b0);
        send_frame(1, 9'h007, 0, 0, 0, 8, 0, 0, 0, -1, 0, 0);   idle(5);
        drive(1, 1'b0); idle(20);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midframe_rst");
        rst = 1'b0; drive(1, 1'b1);
        hv[0] = 1'b0; hv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        set_ready(1'b1); idle(20);
        send_frame(1, 9'h019, 0, 0, 0, 8, 0, 0, 0, -1, 0, 0);   idle(10);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 2000) begin idle(1); wait_cnt++; end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: dut %0d expected at cycle %0d never seen", e.id, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
